mult_rr_sched: RTL and testbench

- Round-robin scheduler that shares one registered multiplier instance among NREQ requesters.
- Each cycle it accepts at most one operand pair over a valid/ready handshake and drives it onto the multiplier inputs.
- It tracks the in-flight tag through a fixed-latency pipe and returns the result to the issuing requester.
- Sits between the ALU request ports and the shared mult unit block. The top level ties the mult reset input to the inverse of rst.

---
 rtl/mult_sched_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 45 ++++
 rtl/mult_rr_sched.sv | 81 ++++++++
 tb/tb_mult_rr_sched.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_sched_pkg.sv
// Shared types and defaults for the round-robin multiplier scheduler.
// The tag layout and operand slicing are sized from the default requester count.
package mult_sched_pkg;
  localparam int NREQ     = 4;
  localparam int IN_WL    = 15;
  localparam int OUT_WL   = 16;
  localparam int MULT_LAT = 1;
  localparam int IDW      = $clog2(NREQ);

  typedef struct packed {
    logic           vld;
    logic [IDW-1:0] id;
  } tag_t;

  function automatic logic [IN_WL-1:0] op_slice(input logic [NREQ*IN_WL-1:0] bus,
                                                input logic [IDW-1:0]        idx);
    return bus[idx*IN_WL +: IN_WL];
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant over NREQ requesters; the pointer moves just past the last winner.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en_i,
  input  logic [NREQ-1:0] req_valid_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  gnt_idx_o,
  output logic            fire_o
);
  logic [IDW-1:0] ptr_q, ptr_d;
  int             j;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    fire_o    = 1'b0;
    j         = 0;
    if (en_i && !rst) begin
      // Walk from the farthest offset back toward the pointer so the nearest valid wins.
      for (int k = NREQ - 1; k >= 0; k--) begin
        j = int'(ptr_q) + k;
        if (j >= NREQ) j = j - NREQ;
        if (req_valid_i[j]) begin
          fire_o    = 1'b1;
          gnt_idx_o = IDW'(j);
        end
      end
      if (fire_o) gnt_o[gnt_idx_o] = 1'b1;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (fire_o) ptr_d = (gnt_idx_o == IDW'(NREQ - 1)) ? '0 : gnt_idx_o + IDW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
endmodule

// File: rtl/mult_rr_sched.sv
// Shares one fixed-latency multiplier among NREQ requesters and routes each
// result back to its issuer via a tag pipe that tracks the multiplier latency.
module mult_rr_sched
  import mult_sched_pkg::*;
#(
  parameter int NREQ     = mult_sched_pkg::NREQ,
  parameter int IN_WL    = mult_sched_pkg::IN_WL,
  parameter int OUT_WL   = mult_sched_pkg::OUT_WL,
  parameter int MULT_LAT = mult_sched_pkg::MULT_LAT,
  parameter int IDW      = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*IN_WL-1:0] req_a,
  input  logic [NREQ*IN_WL-1:0] req_b,
  output logic [IN_WL-1:0]      mult_a,
  output logic [IN_WL-1:0]      mult_b,
  input  logic [OUT_WL-1:0]     mult_r,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [IDW-1:0]        rsp_id,
  output logic [OUT_WL-1:0]     rsp_data,
  output logic                  busy,
  output logic [15:0]           issue_cnt
);
  logic [IDW-1:0]            gnt_idx;
  logic                      fire;
  tag_t [MULT_LAT-1:0]       tag_q;
  tag_t                      tag_d;
  logic [15:0]               cnt_q, cnt_d;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .clk         (clk),
    .rst         (rst),
    .en_i        (en),
    .req_valid_i (req_valid),
    .gnt_o       (req_ready),
    .gnt_idx_o   (gnt_idx),
    .fire_o      (fire)
  );

  always_comb begin
    mult_a = '0;
    mult_b = '0;
    if (fire) begin
      mult_a = op_slice(req_a, gnt_idx);
      mult_b = op_slice(req_b, gnt_idx);
    end
  end

  always_comb begin
    tag_d.vld = fire;
    tag_d.id  = gnt_idx;
    cnt_d     = fire ? cnt_q + 16'd1 : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q <= '0;
      cnt_q <= '0;
    end else begin
      tag_q[0] <= tag_d;
      for (int s = 1; s < MULT_LAT; s++) tag_q[s] <= tag_q[s-1];
      cnt_q <= cnt_d;
    end
  end

  // The strobe is masked during reset so an op caught mid-flight is never reported.
  always_comb begin
    rsp_valid = '0;
    if (tag_q[MULT_LAT-1].vld && !rst) rsp_valid[tag_q[MULT_LAT-1].id] = 1'b1;
    busy = 1'b0;
    for (int s = 0; s < MULT_LAT; s++) busy = busy | tag_q[s].vld;
  end

  assign rsp_id    = tag_q[MULT_LAT-1].id;
  assign rsp_data  = mult_r;
  assign issue_cnt = cnt_q;
endmodule

// File: tb/tb_mult_rr_sched.sv
// Bench for mult_rr_sched: models the shared multiplier, scoreboards every
// issued op against its returned result, and runs table-driven arbitration rows.
module tb_mult_rr_sched;
  localparam int NREQ = 4, IN_WL = 15, OUT_WL = 16, MULT_LAT = 1, IDW = 2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  en  = 1'b1;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*IN_WL-1:0] req_a = '0, req_b = '0;
  logic [IN_WL-1:0]      mult_a, mult_b;
  logic [OUT_WL-1:0]     mult_r;
  logic [NREQ-1:0]       rsp_valid;
  logic [IDW-1:0]        rsp_id;
  logic [OUT_WL-1:0]     rsp_data;
  logic                  busy;
  logic [15:0]           issue_cnt;

  int nerr = 0, nchk = 0;

  mult_rr_sched dut (
    .clk(clk), .rst(rst), .en(en), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .mult_a(mult_a), .mult_b(mult_b), .mult_r(mult_r),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy),
    .issue_cnt(issue_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [OUT_WL-1:0] prod(input logic [IN_WL-1:0] a, input logic [IN_WL-1:0] b);
    logic [31:0] p;
    p = {17'd0, a} * {17'd0, b};
    return p[OUT_WL-1:0];
  endfunction

  // Registered multiplier model
  logic [OUT_WL-1:0] mpipe [MULT_LAT];
  always @(posedge clk) begin
    mpipe[0] <= prod(mult_a, mult_b);
    for (int s = 1; s < MULT_LAT; s++) mpipe[s] <= mpipe[s-1];
  end
  assign mult_r = mpipe[MULT_LAT-1];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    int             due;
    logic [IDW-1:0] id;
    logic [OUT_WL-1:0] data;
  } sb_t;
  sb_t sb[$];

  logic [IDW-1:0] m_ptr = '0;
  logic [15:0]    m_cnt = '0;
  int             cycn  = 0;

  function automatic int model_idx(input logic [IDW-1:0] ptr, input logic [NREQ-1:0] v);
    int j;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  // Scoreboard checker: runs every cycle at the falling edge.
  always @(negedge clk) begin
    int  gi;
    sb_t e;
    logic [NREQ-1:0] eg;
    logic [IN_WL-1:0] ea, eb;
    gi = (rst || !en) ? -1 : model_idx(m_ptr, req_valid);
    eg = '0;
    ea = '0;
    eb = '0;
    if (gi >= 0) begin
      eg[gi] = 1'b1;
      ea = req_a[gi*IN_WL +: IN_WL];
      eb = req_b[gi*IN_WL +: IN_WL];
    end
    chk("sb_ready", req_ready, eg);
    chk("sb_mult_a", mult_a, ea);
    chk("sb_mult_b", mult_b, eb);
    chk("sb_issue_cnt", issue_cnt, m_cnt);
    if (sb.size() > 0 && sb[0].due == cycn) begin
      e = sb.pop_front();
      if (rst) chk("sb_rsp_dropped", rsp_valid, 0);
      else begin
        chk("sb_rsp_valid", rsp_valid, 32'(1) << e.id);
        chk("sb_rsp_id", rsp_id, e.id);
        chk("sb_rsp_data", rsp_data, e.data);
      end
    end else begin
      chk("sb_rsp_idle", rsp_valid, 0);
    end
    if (rst) begin
      sb.delete();
      m_ptr = '0;
      m_cnt = '0;
    end else if (gi >= 0) begin
      e.due  = cycn + MULT_LAT;
      e.id   = IDW'(gi);
      e.data = prod(ea, eb);
      sb.push_back(e);
      m_ptr = IDW'((gi + 1) % NREQ);
      m_cnt = m_cnt + 16'd1;
    end
    cycn++;
  end

  typedef struct {
    logic [NREQ-1:0] vld;
    logic            en;
    logic [NREQ-1:0] exp;
  } row_t;
  row_t tbl[16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic set_ops();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*IN_WL +: IN_WL] = IN_WL'($urandom);
      req_b[i*IN_WL +: IN_WL] = IN_WL'($urandom);
    end
  endtask

  initial begin
    tbl[0]  = '{4'b1111, 1'b1, 4'b0001};
    tbl[1]  = '{4'b1111, 1'b1, 4'b0010};
    tbl[2]  = '{4'b1111, 1'b1, 4'b0100};
    tbl[3]  = '{4'b1111, 1'b1, 4'b1000};
    tbl[4]  = '{4'b1111, 1'b1, 4'b0001};
    tbl[5]  = '{4'b1111, 1'b1, 4'b0010};
    tbl[6]  = '{4'b1111, 1'b1, 4'b0100};
    tbl[7]  = '{4'b1111, 1'b1, 4'b1000};
    tbl[8]  = '{4'b1010, 1'b1, 4'b0010};
    tbl[9]  = '{4'b1010, 1'b1, 4'b1000};
    tbl[10] = '{4'b1010, 1'b1, 4'b0010};
    tbl[11] = '{4'b1010, 1'b1, 4'b1000};
    tbl[12] = '{4'b1111, 1'b0, 4'b0000};
    tbl[13] = '{4'b0100, 1'b1, 4'b0100};
    tbl[14] = '{4'b0000, 1'b1, 4'b0000};
    tbl[15] = '{4'b0001, 1'b1, 4'b0001};

    // Reset state with every requester asking
    rst = 1'b1;
    en = 1'b1;
    req_valid = 4'b1111;
    set_ops();
    repeat (2) begin
      @(negedge clk);
      chk("rst_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_issue_cnt", issue_cnt, 0);
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("first_grant", req_ready, 4'b0001);
    tick();

    // Arbitration rows
    do_reset();
    for (int r = 0; r < 16; r++) begin
      req_valid = tbl[r].vld;
      en = tbl[r].en;
      set_ops();
      @(negedge clk);
      chk($sformatf("row%0d_ready", r), req_ready, tbl[r].exp);
      if (r == 8) chk("rr_issue_cnt8", issue_cnt, 8);
      tick();
    end
    en = 1'b1;

    // Single op from requester 2
    do_reset();
    req_valid = 4'b0100;
    req_a[2*IN_WL +: IN_WL] = 15'd3;
    req_b[2*IN_WL +: IN_WL] = 15'd5;
    @(negedge clk);
    chk("single_ready", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("single_rsp_valid", rsp_valid, 4'b0100);
    chk("single_rsp_id", rsp_id, 2);
    chk("single_rsp_data", rsp_data, 15);
    chk("single_busy", busy, 1);
    tick();
    @(negedge clk);
    chk("single_busy_after", busy, 0);
    tick();

    // Truncation, then 1/3 alternation
    do_reset();
    req_valid = 4'b0010;
    req_a[1*IN_WL +: IN_WL] = 15'h7FFF;
    req_b[1*IN_WL +: IN_WL] = 15'h7FFF;
    @(negedge clk);
    chk("trunc_ready", req_ready, 4'b0010);
    tick();
    req_valid = 4'b1010;
    @(negedge clk);
    chk("trunc_rsp_data", rsp_data, 16'h0001);
    chk("trunc_rsp_id", rsp_id, 1);
    chk("alt_ready3", req_ready, 4'b1000);
    tick();
    @(negedge clk);
    chk("alt_ready1", req_ready, 4'b0010);
    tick();

    // Reset while an op is in flight
    do_reset();
    req_valid = 4'b0001;
    @(negedge clk);
    chk("midrst_fire", req_ready, 4'b0001);
    tick();
    rst = 1'b1;
    req_valid = '0;
    @(negedge clk);
    chk("midrst_rsp_in_rst", rsp_valid, 0);
    tick();
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("midrst_rsp_later", rsp_valid, 0);
      chk("midrst_busy", busy, 0);
      tick();
    end

    // Counter wrap
    do_reset();
    req_valid = 4'b1111;
    repeat (65535) tick();
    @(negedge clk);
    chk("wrap_ffff", issue_cnt, 16'hFFFF);
    chk("wrap_fire", req_ready != 0, 1);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("wrap_zero", issue_cnt, 16'h0000);
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
